// File: rtl/multisim_pkg.sv
// Shared types for the multisim client: stream word, message header layout
// and packer FSM states.
package multisim_pkg;

   typedef bit [63:0] mword_t;

   typedef struct packed {
      logic [15:0] magic;
      logic [15:0] seq;
      logic [15:0] len;
      logic [15:0] rsvd;
   } msg_hdr_t;

   localparam logic [15:0] MAGIC_DEFAULT = 16'hA55A;

   typedef enum logic [1:0] {
      IDLE,
      HEADER,
      PAYLOAD
   } state_t;

endpackage

// File: rtl/multisim_client_msg_packer.sv
// Serialises whole messages into a header word plus payload words on a
// 64-bit valid/ready stream, tagging each message with a sequence number.
//
// state   | meaning
// IDLE    | waiting for a message; msg_rdy high
// HEADER  | header word presented on data
// PAYLOAD | held payload word idx presented on data
module multisim_client_msg_packer
   import multisim_pkg::*;
#(
   parameter int          MAX_WORDS = 8,
   parameter logic [15:0] MAGIC     = MAGIC_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    msg_vld,
   output logic                    msg_rdy,
   input  logic [15:0]             msg_len,
   input  logic [MAX_WORDS*64-1:0] msg_data,
   output logic                    data_vld,
   input  logic                    data_rdy,
   output logic [63:0]             data,
   output logic [15:0]             seq_num,
   output logic                    err_len
);

   localparam int          IDX_W   = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

   state_t      state;
   mword_t      hold [MAX_WORDS];
   logic [15:0] len_q;
   logic [15:0] idx;
   logic [15:0] idx_nxt;
   logic [15:0] len_eff;
   logic        accept;
   logic        xfer;
   msg_hdr_t    hdr;

   assign msg_rdy = (state == IDLE) && !rst;
   assign accept  = msg_vld && msg_rdy;
   assign xfer    = data_vld && data_rdy;
   assign len_eff = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
   assign idx_nxt = idx + 16'd1;

   always_comb begin
      hdr       = '0;
      hdr.magic = MAGIC;
      hdr.seq   = seq_num;
      hdr.len   = len_eff;
      hdr.rsvd  = 16'h0000;
   end

   // Payload is only captured on acceptance, so upstream may change msg_data freely while busy.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < MAX_WORDS; i++) begin
            hold[i] <= msg_data[i*64 +: 64];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         data_vld <= 1'b0;
         data     <= '0;
         seq_num  <= '0;
         err_len  <= 1'b0;
         len_q    <= '0;
         idx      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  len_q    <= len_eff;
                  data     <= hdr;
                  data_vld <= 1'b1;
                  state    <= HEADER;
                  if (msg_len > MAX_LEN) begin
                     err_len <= 1'b1;
                  end
               end
            end
            HEADER: begin
               if (xfer) begin
                  if (len_q == 16'd0) begin
                     state    <= IDLE;
                     data_vld <= 1'b0;
                     data     <= '0;
                     seq_num  <= seq_num + 16'd1;
                  end else begin
                     state <= PAYLOAD;
                     idx   <= '0;
                     data  <= hold[0];
                  end
               end
            end
            PAYLOAD: begin
               if (xfer) begin
                  if (idx == len_q - 16'd1) begin
                     state    <= IDLE;
                     data_vld <= 1'b0;
                     data     <= '0;
                     seq_num  <= seq_num + 16'd1;
                  end else begin
                     idx  <= idx_nxt;
                     data <= hold[idx_nxt[IDX_W-1:0]];
                  end
               end
            end
            default: begin
               state    <= IDLE;
               data_vld <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multisim_client_msg_packer.sv
// Bench for multisim_client_msg_packer: scoreboard of expected stream words
// plus a vector table and a few hand-written multi-cycle sequences.
module tb_multisim_client_msg_packer;

   localparam int MW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              msg_vld;
   logic              msg_rdy;
   logic [15:0]       msg_len;
   logic [MW*64-1:0]  msg_data;
   logic              data_vld;
   logic              data_rdy;
   logic [63:0]       data;
   logic [15:0]       seq_num;
   logic              err_len;

   int          checks = 0;
   int          errors = 0;
   int          xfers  = 0;
   logic [63:0] exp_q [$];
   logic [15:0] seq_m;
   logic        stall_prev = 1'b0;
   logic [63:0] data_prev  = '0;

   typedef struct {
      logic [15:0] len;
      logic [63:0] base;
      logic [15:0] exp_hl;
      logic        exp_err;
   } vec_t;

   multisim_client_msg_packer #(.MAX_WORDS(MW)) dut (
      .clk      (clk),
      .rst      (rst),
      .msg_vld  (msg_vld),
      .msg_rdy  (msg_rdy),
      .msg_len  (msg_len),
      .msg_data (msg_data),
      .data_vld (data_vld),
      .data_rdy (data_rdy),
      .data     (data),
      .seq_num  (seq_num),
      .err_len  (err_len)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stream monitor: sampled mid-cycle, so a word seen with vld&&rdy transfers at the next edge.
   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_vld", 64'(data_vld), 64'd1);
            chk("stall_data", data, data_prev);
         end
         if (data_vld && data_rdy) begin
            xfers++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_word: got %h expected no transfer", data);
            end else begin
               chk("stream_word", data, exp_q.pop_front());
            end
         end
         stall_prev = data_vld && !data_rdy;
         data_prev  = data;
      end
   end

   task automatic send(input logic [15:0] len, input logic [63:0] base,
                       input logic [63:0] step, input logic [15:0] hl);
      int n;
      n = 0;
      while (!msg_rdy && n < 100) begin
         tick();
         n++;
      end
      if (!msg_rdy) begin
         checks++;
         errors++;
         $display("FAIL msg_rdy_timeout: got 0 expected 1");
      end
      msg_vld = 1'b1;
      msg_len = len;
      for (int i = 0; i < MW; i++) msg_data[i*64 +: 64] = base + 64'(i) * step;
      exp_q.push_back({16'hA55A, seq_m, hl, 16'h0000});
      for (int i = 0; i < int'(hl); i++) exp_q.push_back(base + 64'(i) * step);
      seq_m = seq_m + 16'd1;
      tick();
      msg_vld  = 1'b0;
      msg_len  = 16'hDEAD;
      msg_data = '1;
      chk("hdr_latency", 64'(data_vld), 64'd1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !msg_rdy) && n < 200) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0 || !msg_rdy) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs [7];
      int   pat  [6];
      int   low;
      int   x0;

      vecs[0] = '{16'd0,  64'h0,                 16'd0, 1'b0};
      vecs[1] = '{16'd1,  64'hCAFE_0000_0000_0001, 16'd1, 1'b0};
      vecs[2] = '{16'd2,  64'h1000_0000_0000_0000, 16'd2, 1'b0};
      vecs[3] = '{16'd8,  64'h8000_0000_0000_0080, 16'd8, 1'b0};
      vecs[4] = '{16'd20, 64'h2020_2020_0000_0000, 16'd8, 1'b1};
      vecs[5] = '{16'd3,  64'h0303_0000_0000_0003, 16'd3, 1'b1};
      vecs[6] = '{16'd0,  64'hFFFF_0000_0000_0000, 16'd0, 1'b1};
      pat = '{1, 0, 0, 1, 0, 1};

      rst      = 1'b1;
      msg_vld  = 1'b0;
      msg_len  = '0;
      msg_data = '0;
      data_rdy = 1'b1;
      seq_m    = '0;
      repeat (3) tick();
      chk("rst_msg_rdy", 64'(msg_rdy), 64'd0);
      chk("rst_data_vld", 64'(data_vld), 64'd0);
      chk("rst_data", data, 64'd0);
      chk("rst_seq", 64'(seq_num), 64'd0);
      chk("rst_err", 64'(err_len), 64'd0);
      rst = 1'b0;
      #1;
      chk("idle_msg_rdy", 64'(msg_rdy), 64'd1);

      // Basic 3-word message at full rate
      send(16'd3, 64'h11, 64'h11, 16'd3);
      low = 0;
      while (!msg_rdy && low < 50) begin
         low++;
         tick();
      end
      chk("busy_cycles", 64'(low), 64'd4);
      chk("seq_after_first", 64'(seq_num), 64'd1);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);

      for (int v = 0; v < 7; v++) begin
         send(vecs[v].len, vecs[v].base, 64'd1, vecs[v].exp_hl);
         drain();
         chk("vec_seq", 64'(seq_num), 64'(seq_m));
         chk("vec_err", 64'(err_len), 64'(vecs[v].exp_err));
      end

      // Backpressure during a 2-word message
      send(16'd2, 64'hB0B0_0000_0000_0000, 64'd1, 16'd2);
      x0 = xfers;
      for (int k = 0; k < 6; k++) begin
         data_rdy = pat[k][0];
         tick();
      end
      data_rdy = 1'b1;
      chk("stall_xfers", 64'(xfers - x0), 64'd3);
      chk("stall_queue", 64'(exp_q.size()), 64'd0);
      drain();

      // Reset while presenting payload word 1
      send(16'd3, 64'h7700, 64'd1, 16'd3);
      tick();
      tick();
      rst      = 1'b1;
      data_rdy = 1'b0;
      exp_q.delete();
      tick();
      rst      = 1'b0;
      data_rdy = 1'b1;
      seq_m    = '0;
      #1;
      chk("mid_rst_vld", 64'(data_vld), 64'd0);
      chk("mid_rst_rdy", 64'(msg_rdy), 64'd1);
      chk("mid_rst_seq", 64'(seq_num), 64'd0);
      chk("mid_rst_err", 64'(err_len), 64'd0);
      send(16'd0, 64'h0, 64'd1, 16'd0);
      drain();
      chk("post_rst_seq", 64'(seq_num), 64'd1);

      // Sequence wrap: preload the counter near the top instead of sending 64k messages
      dut.seq_num = 16'hFFFD;
      seq_m       = 16'hFFFD;
      for (int m = 0; m < 4; m++) begin
         send(16'd0, 64'h0, 64'd1, 16'd0);
         drain();
         chk("wrap_seq", 64'(seq_num), 64'(seq_m));
      end
      chk("wrap_final", 64'(seq_num), 64'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
